// File: rtl/shield_pkg.sv
// Shared types and constants for the shield deviation controller.
package shield_pkg;

  localparam int unsigned TS_W  = 16;
  localparam int unsigned OUT_W = 4;

  // Bit positions of the guarded outputs inside {a1,a2,b1,b2}
  localparam int unsigned BIT_A1 = 3;
  localparam int unsigned BIT_A2 = 2;
  localparam int unsigned BIT_B1 = 1;
  localparam int unsigned BIT_B2 = 0;

  typedef enum logic [1:0] {
    ModeIdle    = 2'd0,
    ModeMonitor = 2'd1,
    ModeRecover = 2'd2,
    ModeFault   = 2'd3
  } mode_e;

endpackage

// File: rtl/shield_deviation_ctrl_if.sv
// Host-facing signal bundle of the shield deviation controller.
interface shield_deviation_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  import shield_pkg::*;

  logic             en;
  logic             clr;
  logic [OUT_W-1:0] sys_out;
  logic [OUT_W-1:0] shd_out;
  mode_e            mode;
  logic             dev;
  logic [OUT_W-1:0] dev_mask;
  logic             fault;
  logic [CNT_W-1:0] dev_count;
  logic             evt_valid;
  logic             evt_ready;
  logic [OUT_W-1:0] evt_mask;
  logic [TS_W-1:0]  evt_time;
  logic             evt_ovf;

  // Host / environment side
  modport master (
    output en, clr, sys_out, shd_out, evt_ready,
    input  mode, dev, dev_mask, fault, dev_count, evt_valid, evt_mask, evt_time, evt_ovf
  );

  // Controller side
  modport slave (
    input  en, clr, sys_out, shd_out, evt_ready,
    output mode, dev, dev_mask, fault, dev_count, evt_valid, evt_mask, evt_time, evt_ovf
  );

endinterface

// File: rtl/shield_evt_buf.sv
// Single-entry valid/ready event register with a sticky drop flag.
module shield_evt_buf #(
  parameter int unsigned W = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] data,
  input  logic         ready,
  input  logic         clr_ovf,
  output logic         valid,
  output logic [W-1:0] payload,
  output logic         ovf
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         ovf_q, ovf_d;
  logic         load;

  // Load when empty or being drained this cycle; otherwise a push is dropped
  always_comb begin
    load    = push && (!valid_q || ready);
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data;
    end else if (push) begin
      ovf_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid   = valid_q;
  assign payload = data_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/shield_deviation_ctrl.sv
// Supervisor beside a synthesized shield: tracks how often the shield overrides
// the system, sequences monitor/recover/fault and reports each deviation.
module shield_deviation_ctrl
  import shield_pkg::*;
#(
  parameter int unsigned WINDOW      = 16,
  parameter int unsigned MAX_DEV     = 4,
  parameter int unsigned RECOVER_CYC = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  shield_deviation_ctrl_if.slave  bus
);

  localparam int unsigned WC_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int unsigned WD_W = $clog2(MAX_DEV + 1);
  localparam int unsigned RC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  mode_e            mode_q, mode_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [WD_W-1:0]  win_dev_q, win_dev_d;
  logic [CNT_W-1:0] dev_count_q, dev_count_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic             dev_q;
  logic [OUT_W-1:0] dev_mask_q;

  logic             active;
  logic [OUT_W-1:0] mask;
  logic             dev_now;
  logic             wrap;
  logic [WD_W-1:0]  win_sum;
  logic             hit;
  logic [OUT_W+TS_W-1:0] evt_payload;

  // Deviation detection and window accounting for this cycle; clr masks deviations
  always_comb begin
    active  = (mode_q == ModeMonitor) || (mode_q == ModeRecover);
    mask    = bus.sys_out ^ bus.shd_out;
    dev_now = active && (mask != '0) && !bus.clr;
    wrap    = active && (wcnt_q == WC_W'(WINDOW - 1));
    // A deviation on the wrap cycle belongs to the new window
    win_sum = (wrap ? '0 : win_dev_q) + WD_W'(dev_now);
    hit     = dev_now && (win_sum >= WD_W'(MAX_DEV));
  end

  // Mode sequencing; clr and a window overrun take precedence
  always_comb begin
    mode_d = mode_q;
    rcnt_d = rcnt_q;
    if (bus.clr) begin
      mode_d = bus.en ? ModeMonitor : ModeIdle;
      rcnt_d = '0;
    end else begin
      unique case (mode_q)
        ModeIdle: begin
          if (bus.en) mode_d = ModeMonitor;
        end
        ModeMonitor, ModeRecover: begin
          if (hit) begin
            mode_d = ModeFault;
          end else if (!bus.en) begin
            mode_d = ModeIdle;
          end else if (dev_now) begin
            mode_d = ModeRecover;
            rcnt_d = RC_W'(RECOVER_CYC - 1);
          end else if (mode_q == ModeRecover) begin
            if (rcnt_q == '0) mode_d = ModeMonitor;
            else              rcnt_d = rcnt_q - 1'b1;
          end
        end
        ModeFault: ;
        default: mode_d = ModeIdle;
      endcase
    end
  end

  // Window, total counter and timestamp next state
  always_comb begin
    wcnt_d      = wcnt_q;
    win_dev_d   = win_dev_q;
    dev_count_d = dev_count_q;
    ts_d        = bus.en ? ts_q + 1'b1 : ts_q;
    if (bus.clr) begin
      wcnt_d      = '0;
      win_dev_d   = '0;
      dev_count_d = '0;
    end else begin
      if (active) begin
        wcnt_d    = wrap ? '0 : wcnt_q + 1'b1;
        win_dev_d = win_sum;
      end
      if (dev_now && (dev_count_q != {CNT_W{1'b1}})) begin
        dev_count_d = dev_count_q + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q      <= ModeIdle;
      rcnt_q      <= '0;
      wcnt_q      <= '0;
      win_dev_q   <= '0;
      dev_count_q <= '0;
      ts_q        <= '0;
      dev_q       <= 1'b0;
      dev_mask_q  <= '0;
    end else begin
      mode_q      <= mode_d;
      rcnt_q      <= rcnt_d;
      wcnt_q      <= wcnt_d;
      win_dev_q   <= win_dev_d;
      dev_count_q <= dev_count_d;
      ts_q        <= ts_d;
      dev_q       <= dev_now;
      dev_mask_q  <= mask;
    end
  end

  shield_evt_buf #(
    .W (OUT_W + TS_W)
  ) u_evt_buf (
    .clock   (clock),
    .reset   (reset),
    .push    (dev_now),
    .data    ({mask, ts_q}),
    .ready   (bus.evt_ready),
    .clr_ovf (bus.clr),
    .valid   (bus.evt_valid),
    .payload (evt_payload),
    .ovf     (bus.evt_ovf)
  );

  assign bus.mode      = mode_q;
  assign bus.fault     = (mode_q == ModeFault);
  assign bus.dev       = dev_q;
  assign bus.dev_mask  = dev_mask_q;
  assign bus.dev_count = dev_count_q;
  assign bus.evt_mask  = evt_payload[OUT_W+TS_W-1:TS_W];
  assign bus.evt_time  = evt_payload[TS_W-1:0];

endmodule

// File: tb/tb_shield_deviation_ctrl.sv
// Bench for shield_deviation_ctrl: behavioural model plus directed literal checks.
module tb_shield_deviation_ctrl;
  import shield_pkg::*;

  localparam int WINDOW      = 16;
  localparam int MAX_DEV     = 4;
  localparam int RECOVER_CYC = 2;
  localparam int CNT_W       = 8;

  logic clock = 1'b0;
  logic reset;

  shield_deviation_ctrl_if #(.CNT_W(CNT_W)) bus ();

  shield_deviation_ctrl #(
    .WINDOW      (WINDOW),
    .MAX_DEV     (MAX_DEV),
    .RECOVER_CYC (RECOVER_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Model: expected outputs plus window bookkeeping by absolute active-cycle index
  int m_mode, m_rc, m_act, m_win_id, m_win_n, m_total, m_ts, m_ev_time;
  bit m_dev, m_ev_v, m_ovf;
  logic [3:0] m_mask, m_ev_mask;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Evaluate the rules for the upcoming edge, then commit after it
  task automatic tick();
    int mode = m_mode, rc = m_rc, actc = m_act, wid = m_win_id, wn = m_win_n;
    int total = m_total, ts = m_ts, evt = m_ev_time;
    bit dv = m_dev, ev = m_ev_v, ovf = m_ovf;
    logic [3:0] dm = m_mask, em = m_ev_mask;
    logic [3:0] mask;
    bit act, devn, hit;
    if (reset) begin
      mode = 0; rc = 0; actc = 0; wid = 0; wn = 0; total = 0; ts = 0; evt = 0;
      dv = 0; ev = 0; ovf = 0; dm = 0; em = 0;
    end else begin
      mask = bus.sys_out ^ bus.shd_out;
      act  = (m_mode == 1) || (m_mode == 2);
      devn = act && (mask != 0) && !bus.clr;
      hit  = 1'b0;
      if (bus.clr) begin
        actc = 0; wid = 0; wn = 0;
      end else if (act) begin
        if ((m_act + 1) / WINDOW != wid) begin
          wid = (m_act + 1) / WINDOW;
          wn  = 0;
        end
        if (devn) wn++;
        hit  = devn && (wn >= MAX_DEV);
        actc = m_act + 1;
      end
      if (devn) begin
        if (!m_ev_v || bus.evt_ready) begin
          ev = 1; em = mask; evt = m_ts;
        end else begin
          ovf = 1;
        end
      end else if (m_ev_v && bus.evt_ready) begin
        ev = 0;
      end
      if (bus.clr) ovf = 0;
      if (bus.clr) total = 0;
      else if (devn && total < (1 << CNT_W) - 1) total++;
      if (bus.clr) begin
        mode = bus.en ? 1 : 0;
        rc   = 0;
      end else if (m_mode == 0) begin
        if (bus.en) mode = 1;
      end else if (act) begin
        if (hit) mode = 3;
        else if (!bus.en) mode = 0;
        else if (devn) begin mode = 2; rc = RECOVER_CYC - 1; end
        else if (m_mode == 2) begin
          if (m_rc == 0) mode = 1;
          else rc = m_rc - 1;
        end
      end
      dv = devn;
      dm = mask;
      if (bus.en) ts = (m_ts + 1) % 65536;
    end
    @(posedge clock);
    m_mode = mode; m_rc = rc; m_act = actc; m_win_id = wid; m_win_n = wn;
    m_total = total; m_ts = ts; m_ev_time = evt; m_dev = dv; m_ev_v = ev;
    m_ovf = ovf; m_mask = dm; m_ev_mask = em;
    #2;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_on) begin
      cmp("mode",      int'(bus.mode),   m_mode);
      cmp("fault",     int'(bus.fault),  int'(m_mode == 3));
      cmp("dev",       int'(bus.dev),    int'(m_dev));
      cmp("dev_mask",  int'(bus.dev_mask), int'(m_mask));
      cmp("dev_count", int'(bus.dev_count), m_total);
      cmp("evt_valid", int'(bus.evt_valid), int'(m_ev_v));
      cmp("evt_mask",  int'(bus.evt_mask), int'(m_ev_mask));
      cmp("evt_time",  int'(bus.evt_time), m_ev_time);
      cmp("evt_ovf",   int'(bus.evt_ovf),  int'(m_ovf));
    end
  end

  task automatic drive(input logic [3:0] sys, input logic [3:0] shd);
    bus.sys_out = sys;
    bus.shd_out = shd;
  endtask

  initial begin
    reset = 1'b1;
    bus.en = 1'b0; bus.clr = 1'b0; bus.evt_ready = 1'b0;
    drive(4'b0000, 4'b0000);
    tick();
    chk_on = 1'b1;
    tick();
    cmp("lit_rst_mode", int'(bus.mode), 0);
    cmp("lit_rst_evt_valid", int'(bus.evt_valid), 0);

    // Quiet monitoring
    reset = 1'b0;
    bus.en = 1'b1;
    repeat (20) tick();
    cmp("lit_quiet_mode", int'(bus.mode), 1);
    cmp("lit_quiet_dev", int'(bus.dev), 0);
    cmp("lit_quiet_count", int'(bus.dev_count), 0);

    // Single mismatch at ts=3
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (3) tick();
    drive(4'b1001, 4'b1000); tick();
    cmp("lit_single_mask", int'(bus.dev_mask), 1);
    cmp("lit_single_mode", int'(bus.mode), 2);
    cmp("lit_single_time", int'(bus.evt_time), 3);
    drive(4'b0000, 4'b0000); tick();
    cmp("lit_recover_hold", int'(bus.mode), 2);
    tick();
    cmp("lit_recover_exit", int'(bus.mode), 1);

    // Overflow, back-to-back handshake and fault
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    drive(4'b0010, 4'b0000); tick();
    drive(4'b0000, 4'b0000); tick();
    drive(4'b0100, 4'b0000); tick();
    cmp("lit_ovf_mask", int'(bus.evt_mask), 2);
    cmp("lit_ovf_time", int'(bus.evt_time), 1);
    cmp("lit_ovf_flag", int'(bus.evt_ovf), 1);
    cmp("lit_ovf_count", int'(bus.dev_count), 2);
    bus.evt_ready = 1'b1;
    drive(4'b1000, 4'b0000); tick();
    cmp("lit_b2b_valid", int'(bus.evt_valid), 1);
    cmp("lit_b2b_mask", int'(bus.evt_mask), 8);
    cmp("lit_b2b_time", int'(bus.evt_time), 4);
    drive(4'b0000, 4'b0000); tick();
    cmp("lit_drain_valid", int'(bus.evt_valid), 0);
    bus.evt_ready = 1'b0;
    drive(4'b0001, 4'b0000); tick();
    cmp("lit_fault_mode", int'(bus.mode), 3);
    cmp("lit_fault_flag", int'(bus.fault), 1);
    cmp("lit_fault_count", int'(bus.dev_count), 4);
    drive(4'b1111, 4'b0000); tick(); tick();
    cmp("lit_fault_frozen", int'(bus.dev_count), 4);
    drive(4'b0000, 4'b0000);
    bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    cmp("lit_clr_mode", int'(bus.mode), 1);
    cmp("lit_clr_count", int'(bus.dev_count), 0);
    cmp("lit_clr_ovf", int'(bus.evt_ovf), 0);
    cmp("lit_clr_keep_evt", int'(bus.evt_time), 6);

    // Window wrap: the wrap-cycle deviation counts toward the new window
    for (int j = 0; j < 22; j++) begin
      bus.evt_ready = (j < 20);
      if (j == 0 || j == 2 || j == 4 || j == 15 || j == 17 || j == 19 || j == 21)
        drive(4'b0100, 4'b0000);
      else
        drive(4'b0000, 4'b0000);
      tick();
      if (j == 19) cmp("lit_wrap_nofault", int'(bus.mode), 2);
      if (j == 21) begin
        cmp("lit_wrap_fault", int'(bus.mode), 3);
        cmp("lit_wrap_count", int'(bus.dev_count), 7);
      end
    end
    drive(4'b0000, 4'b0000); tick();
    cmp("lit_pre_rst_valid", int'(bus.evt_valid), 1);

    // Reset out of FAULT with a pending event
    reset = 1'b1; tick();
    cmp("lit_mid_rst_mode", int'(bus.mode), 0);
    cmp("lit_mid_rst_valid", int'(bus.evt_valid), 0);
    cmp("lit_mid_rst_time", int'(bus.evt_time), 0);
    reset = 1'b0; bus.en = 1'b0;
    repeat (2) tick();

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shield_deviation_ctrl.md
# shield_deviation_ctrl

Supervisory controller placed beside a synthesized shield: each cycle it compares the system's proposed outputs {a1,a2,b1,b2} with the shield's corrected outputs. It sequences a monitor/recover/fault state machine, counts deviations per fixed window and in total, and raises a sticky fault when the shield intervenes too often. Each deviation is reported to a host through a single-entry valid/ready event register.

## Interface
- WINDOW, 16: window length in cycles (≥2)
- MAX_DEV, 4: deviations within one window that trigger FAULT (≥1, ≤WINDOW)
- RECOVER_CYC, 2: cycles spent in RECOVER after the last deviation (≥1)
- CNT_W, 8: width of total deviation counter
- clock  in  1  rising-edge clock
- reset  in  1  reset; one clock, synchronous, active-high
- en  in  1  monitoring enable
- clr  in  1  clears fault, overflow, counters and window
- sys_out  in  4  system outputs {a1,a2,b1,b2}, bit 3 = a1
- shd_out  in  4  shield outputs, same order
- mode  out  2  IDLE=0, MONITOR=1, RECOVER=2, FAULT=3
- dev  out  1  registered: deviation sampled on previous edge
- dev_mask  out  4  registered sys_out^shd_out of previous edge
- fault  out  1  high iff mode==FAULT
- dev_count  out  CNT_W  saturating total deviation count
- evt_valid  out  1  event record pending
- evt_ready  in  1  host accepts event
- evt_mask  out  4  mismatch mask of the held event
- evt_time  out  16  timestamp of the held event
- evt_ovf  out  1  sticky: an event was dropped

## Operation
- Deviation: active = (mode≠IDLE && mode≠FAULT); deviation = active && (sys_out≠shd_out).
- FSM, evaluated on each edge, with clr taking priority over reset-free transitions:
  - IDLE: en → MONITOR.
  - MONITOR: !en → IDLE; deviation → RECOVER with rcnt=RECOVER_CYC-1.
  - RECOVER: !en → IDLE; a deviation reloads rcnt; rcnt==0 with no deviation → MONITOR; otherwise rcnt decrements.
  - Any active state: a deviation that makes the window count reach MAX_DEV → FAULT; this has priority over RECOVER.
  - FAULT: held until clr; clr → MONITOR if en, else IDLE.
- Window: wcnt counts 0..WINDOW-1 while active, then wraps. On wrap, win_dev is set to the deviation bit of that same cycle, so a deviation on a wrap cycle counts toward the new window.
- dev_count increments on each deviation and saturates at 2^CNT_W-1.
- Timestamp ts[15:0] is free-running while en is high and wraps at 0xFFFF. It is not cleared by clr.
- Event register:
  - A deviation loads {mask, ts} when !evt_valid or (evt_valid && evt_ready).
  - Otherwise the new event is dropped and evt_ovf is set.
  - evt_valid && evt_ready with no new deviation → evt_valid=0.
- clr: zeroes dev_count, win_dev, wcnt, evt_ovf and leaves FAULT. A deviation in the same cycle is ignored. A pending event is kept.

## Timing
- Every output is registered, so latency is 1 edge from the sampled inputs.
- Reset values: mode=IDLE, dev=0, dev_mask=0, dev_count=0, evt_valid=0, evt_mask=0, evt_time=0, evt_ovf=0, fault=0. Internal wcnt, win_dev, rcnt and ts are also 0.
- Reset mid-operation overrides everything, including a pending event and FAULT.
- evt_mask and evt_time are stable while evt_valid && !evt_ready.
- A handshake and a reload in the same cycle give back-to-back events with no bubble.
- FAULT is entered on the edge that samples the MAX_DEV-th deviation. fault is high the cycle after.

## Structure
- Shared package shield_pkg holds:
  - mode enum (IDLE/MONITOR/RECOVER/FAULT, 2-bit)
  - TS_W=16 and OUT_W=4 constants
  - the bit-order constants for {a1,a2,b1,b2}
- Sub-module shield_evt_buf holds the single-entry valid/ready register with overflow flag. It is parameterized on payload width OUT_W+TS_W.
- The FSM, the counters and the timestamp stay in the top module.

## Test plan
- Reset, then en=1 with matching outputs for 20 cycles → mode=1, dev=0, evt_valid=0, dev_count=0.
- Single mismatch sys=4'b1001, shd=4'b1000 at ts=3, evt_ready=0 → dev_mask=4'b0001, mode=2 for 2 cycles then 1, evt_time=3.
- Two mismatches 1 cycle apart while evt_ready=0 → first event held, evt_ovf=1, dev_count=2.
- 4 mismatches inside one 16-cycle window → mode=3 and fault=1 on the next cycle. Further mismatches do not change dev_count. clr with en=1 → mode=1, dev_count=0.
- 3 mismatches, the window wraps, then 3 more → no FAULT. A mismatch on the wrap cycle leaves win_dev=1.
- reset asserted while in FAULT with evt_valid=1 → all outputs are zero on the next cycle.
